// File: rtl/sc_bit_scheduler.sv
// Walks leaf indices 0..N-1 of one SC decode: 2 cycles per frozen bit and 3 per info bit; done follows the last ack.
// Waits in REQ for llr_valid and holds u_hat/u_valid in EMIT until ps_ack. abort returns to IDLE from any busy state.
module sc_bit_scheduler #(
    parameter int n = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [n-1:0]      bit_index,
    output logic              idx_valid,
    input  logic              frozen_ind,
    output logic              llr_req,
    input  logic              llr_valid,
    input  logic              llr_sign,
    output logic              u_hat,
    output logic              u_valid,
    input  logic              ps_ack,
    output logic [(2**n)-1:0] decoded,
    output logic [n:0]        frozen_cnt,
    output logic              busy,
    output logic              done
);

    localparam int N = 2**n;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   bit_index_q, bit_index_d;
    logic           u_hat_q, u_hat_d;
    logic [N-1:0]   decoded_q, decoded_d;
    logic [n:0]     frozen_cnt_q, frozen_cnt_d;

    always_comb begin
        state_d      = state_q;
        bit_index_d  = bit_index_q;
        u_hat_d      = u_hat_q;
        decoded_d    = decoded_q;
        frozen_cnt_d = frozen_cnt_q;
        // An abort freezes every datapath register, so a same-cycle ack or LLR is dropped.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d      = S_FETCH;
                        bit_index_d  = '0;
                        decoded_d    = '0;
                        frozen_cnt_d = '0;
                    end
                end
                S_FETCH: begin
                    if (frozen_ind) begin
                        u_hat_d      = 1'b0;
                        frozen_cnt_d = frozen_cnt_q + (n+1)'(1);
                        state_d      = S_EMIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (llr_valid) begin
                        u_hat_d = llr_sign;
                        state_d = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (ps_ack) begin
                        decoded_d[bit_index_q] = u_hat_q;
                        if (bit_index_q == n'(N-1)) begin
                            state_d = S_DONE;
                        end else begin
                            bit_index_d = bit_index_q + n'(1);
                            state_d     = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_index_q  <= '0;
            u_hat_q      <= 1'b0;
            decoded_q    <= '0;
            frozen_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_index_q  <= bit_index_d;
            u_hat_q      <= u_hat_d;
            decoded_q    <= decoded_d;
            frozen_cnt_q <= frozen_cnt_d;
        end
    end

    assign bit_index  = bit_index_q;
    assign u_hat      = u_hat_q;
    assign decoded    = decoded_q;
    assign frozen_cnt = frozen_cnt_q;
    assign idx_valid  = (state_q == S_FETCH);
    assign llr_req    = (state_q == S_REQ);
    assign u_valid    = (state_q == S_EMIT);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sc_bit_scheduler.sv
// Directed and random codewords for sc_bit_scheduler (n=3), scored against a per-index decision model.
module tb_sc_bit_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, abort, llr_valid, ps_ack;
    logic       frozen_ind, llr_sign;
    logic [2:0] bit_index;
    logic       idx_valid, llr_req, u_hat, u_valid, busy, done;
    logic [7:0] decoded;
    logic [3:0] frozen_cnt;

    logic [7:0] fmask = 8'h00;
    logic [7:0] smask = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Frozen-bit register and SC tree modelled as lookups on the served index.
    assign frozen_ind = fmask[bit_index];
    assign llr_sign   = smask[bit_index];

    sc_bit_scheduler #(.n(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bit_index(bit_index), .idx_valid(idx_valid), .frozen_ind(frozen_ind),
        .llr_req(llr_req), .llr_valid(llr_valid), .llr_sign(llr_sign),
        .u_hat(u_hat), .u_valid(u_valid), .ps_ack(ps_ack),
        .decoded(decoded), .frozen_cnt(frozen_cnt), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {11'd0, busy, done, idx_valid, llr_req, u_valid, u_hat, bit_index, frozen_cnt, decoded};
    endfunction

    function automatic int exp_cycles(input logic [7:0] fm);
        int c = 1;
        for (int i = 0; i < 8; i++) c += fm[i] ? 2 : 3;
        return c;
    endfunction

    // Runs one codeword. rnd: random handshakes and stray start pulses.
    // stall_idx: hold ps_ack low 5 cycles in EMIT of that index. abort_idx: abort with ps_ack there.
    task automatic run_cw(input string name, input logic [7:0] fm, input logic [7:0] sm,
                          input bit rnd, input int stall_idx, input int abort_idx);
        int cyc = 0, exp_idx = 0, episodes = 0, stall_n = 0;
        bit prev_req = 0, aborted = 0, fin = 0;
        logic [7:0] exp_dec;
        fmask = fm;
        smask = sm;
        exp_dec = sm & ~fm;
        @(negedge clk);
        start = 1'b1; llr_valid = 1'b1; ps_ack = 1'b1; abort = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(negedge clk);
            cyc++;
            if (aborted) begin
                abort = 1'b0; start = 1'b0;
                chk({name, " abort->idle"}, {30'd0, busy, done}, 32'd0);
                chk({name, " abort decoded"}, decoded, exp_dec & 8'h1F);
                chk({name, " abort frozen_cnt"}, frozen_cnt, $countones(fm[5:0]));
                fin = 1;
            end else if (done) begin
                start = 1'b0;
                fin = 1;
            end else begin
                start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                if (llr_req && !prev_req) episodes++;
                prev_req  = llr_req;
                llr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                ps_ack    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (u_valid && int'(bit_index) == stall_idx && stall_n < 5) begin
                    chk({name, " stall idx"}, bit_index, stall_idx);
                    chk({name, " stall u_hat"}, u_hat, exp_dec[stall_idx]);
                    ps_ack = 1'b0;
                    stall_n++;
                end
                if (u_valid && int'(bit_index) == abort_idx) begin
                    abort = 1'b1; ps_ack = 1'b1; start = 1'b0; aborted = 1;
                end else if (u_valid && ps_ack) begin
                    chk({name, " commit idx"}, bit_index, exp_idx);
                    chk({name, " commit u_hat"}, u_hat, exp_dec[exp_idx]);
                    exp_idx++;
                end
            end
        end
        if (!fin) chk({name, " timeout"}, 32'd0, 32'd1);
        else if (!aborted) begin
            chk({name, " decoded"}, decoded, exp_dec);
            chk({name, " frozen_cnt"}, frozen_cnt, $countones(fm));
            chk({name, " bits done"}, exp_idx, 8);
            chk({name, " final idx"}, bit_index, 3'd7);
            if (!rnd) begin
                chk({name, " done cycle"}, cyc, exp_cycles(fm) + ((stall_idx >= 0) ? 5 : 0));
                chk({name, " llr episodes"}, episodes, 8 - $countones(fm));
            end
            @(negedge clk);
            chk({name, " done pulse"}, {30'd0, busy, done}, 32'd0);
            chk({name, " decoded hold"}, decoded, exp_dec);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; llr_valid = 1'b0; ps_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", out_vec(), 32'd0);
        rst = 1'b0;

        run_cw("all_frozen", 8'hFF, 8'hFF, 1'b0, -1, -1);
        run_cw("all_info",   8'h00, 8'hFF, 1'b0, -1, -1);
        run_cw("mask_0124",  8'h17, 8'hFF, 1'b0, -1, -1);
        chk("mask_0124 E8", decoded, 8'hE8);
        run_cw("stall_3",    8'h17, 8'h5A, 1'b0, 3, -1);
        run_cw("abort_5",    8'h0C, 8'hFF, 1'b0, -1, 5);
        run_cw("after_abort", 8'h81, 8'h3C, 1'b0, -1, -1);
        for (int r = 0; r < 20; r++)
            run_cw("random", 8'($urandom), 8'($urandom), 1'b1, -1, -1);

        // Reset while waiting for an LLR.
        fmask = 8'h00; llr_valid = 1'b0; ps_ack = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 10 && !llr_req; k++) @(negedge clk);
        chk("reach REQ", llr_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst in REQ", out_vec(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after rst", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
